// File: rtl/game_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | game_pkg : game state encoding, score width and ball centre        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package game_pkg;
    import vga_pkg::*;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE     = 2'd1,
        PLAY      = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    localparam int SCORE_W = 4;

    localparam logic [10:0] BALL_X_CENTRE = 11'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  BALL_Y_CENTRE = 10'((V_ACTIVE - BALL_SIZE) / 2);

    // Ball box [y, y+BALL_SIZE] touches pad span [pad, pad+PAD_HEIGHT]; 11 bits avoids wrap.
    function automatic logic pad_overlap(input logic [9:0] y_top, input logic [9:0] pad_top);
        logic [10:0] b;
        logic [10:0] p;
        b = {1'b0, y_top};
        p = {1'b0, pad_top};
        return ((b + 11'(BALL_SIZE)) >= p) && (b <= (p + 11'(PAD_HEIGHT)));
    endfunction
endpackage
`default_nettype wire

// File: rtl/vga_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_pkg : 1024x768 display geometry shared by the pong blocks     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package vga_pkg;
    localparam int H_ACTIVE    = 1024;
    localparam int V_ACTIVE    = 768;
    localparam int BALL_SIZE   = 16;
    localparam int X_PAD_LEFT  = 32;
    localparam int X_PAD_RIGHT = 976;
    localparam int PAD_WIDTH   = 16;
    localparam int PAD_HEIGHT  = 128;
endpackage
`default_nettype wire

// File: rtl/frame_tick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | frame_tick : one-cycle pulse on each vblnk rising edge            |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module frame_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vblnk,
    output logic o_tick
);
    logic vblnk_q;
    logic vblnk_d;

    always_comb begin
        vblnk_d = i_vblnk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q <= 1'b0;
        end else begin
            vblnk_q <= vblnk_d;
        end
    end

    assign o_tick = i_vblnk & ~vblnk_q;
endmodule
`default_nettype wire

// File: rtl/ball_ctl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ball_ctl : per-frame pong sequencer (serve/play/score/game over). |
// | Optional BALL_CTL_SPEEDUP_EN: |dx| grows every 4th pad hit.       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module ball_ctl
    import vga_pkg::*;
    import game_pkg::*;
#(
    parameter int STEP_X       = 4,
    parameter int STEP_Y       = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9,
    parameter int MAX_STEP_X   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vblnk,
    input  logic                start,
    input  logic [9:0]          y_pad_left,
    input  logic [9:0]          y_pad_right,
    output logic [10:0]         x_ball,
    output logic [9:0]          y_ball,
    output logic [SCORE_W-1:0]  score_left,
    output logic [SCORE_W-1:0]  score_right,
    output logic                game_over
);
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam int MAG_W = $clog2(MAX_STEP_X + 1);

    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    localparam logic signed [11:0] XL    = 12'(X_PAD_LEFT + PAD_WIDTH);
    localparam logic signed [11:0] XR    = 12'(X_PAD_RIGHT - BALL_SIZE);
    localparam logic signed [11:0] X_MAX = 12'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX = 12'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] DY    = 12'(STEP_Y);

    localparam logic [10:0] X_BOUNCE_L = 11'(X_PAD_LEFT + PAD_WIDTH + 1);
    localparam logic [10:0] X_BOUNCE_R = 11'(X_PAD_RIGHT - BALL_SIZE - 1);
    localparam logic [9:0]  Y_BOTTOM   = 10'(V_ACTIVE - BALL_SIZE);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [10:0]          x_q, x_d;
    logic [9:0]           y_q, y_d;
    logic [SCORE_W-1:0]   score_l_q, score_l_d;
    logic [SCORE_W-1:0]   score_r_q, score_r_d;
    logic                 game_over_q, game_over_d;
    logic                 dx_neg_q, dx_neg_d;
    logic                 dy_neg_q, dy_neg_d;

    logic                 w_tick;
    logic [MAG_W-1:0]     w_mag;
    logic signed [11:0]   w_mag_s;
    logic signed [11:0]   w_dx;
    logic signed [11:0]   w_dy;
    logic signed [11:0]   w_x_s;
    logic signed [11:0]   w_x_n;
    logic signed [11:0]   w_y_n;
    logic                 w_hit_l;
    logic                 w_hit_r;
    logic                 point;

    frame_tick u_frame_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vblnk (vblnk),
        .o_tick  (w_tick)
    );

`ifdef BALL_CTL_SPEEDUP_EN
    localparam logic [MAG_W-1:0] MAG_INIT = MAG_W'(STEP_X);
    localparam logic [MAG_W-1:0] MAG_MAX  = MAG_W'(MAX_STEP_X);
    logic [MAG_W-1:0] mag_q, mag_d;
    logic [1:0]       hits_q, hits_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q  <= MAG_INIT;
            hits_q <= 2'd0;
        end else begin
            mag_q  <= mag_d;
            hits_q <= hits_d;
        end
    end

    assign w_mag = mag_q;
`else
    assign w_mag = MAG_W'(STEP_X);
`endif

    assign w_mag_s = $signed(12'(w_mag));
    assign w_dx    = dx_neg_q ? -w_mag_s : w_mag_s;
    assign w_dy    = dy_neg_q ? -DY : DY;
    assign w_x_s   = $signed({1'b0, x_q});
    assign w_x_n   = w_x_s + w_dx;
    assign w_y_n   = $signed({2'b0, y_q}) + w_dy;

    // Pad hits only count when the ball crosses the pad face this frame.
    assign w_hit_l = dx_neg_q && (w_x_s > XL) && (w_x_n <= XL) && pad_overlap(y_q, y_pad_left);
    assign w_hit_r = !dx_neg_q && (w_x_s < XR) && (w_x_n >= XR) && pad_overlap(y_q, y_pad_right);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        dx_neg_d  = dx_neg_q;
        dy_neg_d  = dy_neg_q;
        point     = 1'b0;
`ifdef BALL_CTL_SPEEDUP_EN
        mag_d     = mag_q;
        hits_d    = hits_q;
`endif
        // start is a level from a debounced button, so IDLE/GAME_OVER accept it on any cycle.
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SERVE;
                    cnt_d   = SERVE_LOAD;
                end
            end
            SERVE: begin
                if (w_tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = PLAY;
                    end
                end
            end
            PLAY: begin
                if (w_tick) begin
                    if (w_y_n <= 12'sd0) begin
                        y_d      = 10'd0;
                        dy_neg_d = 1'b0;
                    end else if (w_y_n >= Y_MAX) begin
                        y_d      = Y_BOTTOM;
                        dy_neg_d = 1'b1;
                    end else begin
                        y_d = w_y_n[9:0];
                    end

                    if (w_hit_l) begin
                        x_d      = X_BOUNCE_L;
                        dx_neg_d = 1'b0;
                    end else if (w_hit_r) begin
                        x_d      = X_BOUNCE_R;
                        dx_neg_d = 1'b1;
                    end else if (w_x_n <= 12'sd0) begin
                        score_r_d = (score_r_q >= WIN_S) ? WIN_S : score_r_q + SCORE_ONE;
                        dx_neg_d  = 1'b1;
                        point     = 1'b1;
                    end else if (w_x_n >= X_MAX) begin
                        score_l_d = (score_l_q >= WIN_S) ? WIN_S : score_l_q + SCORE_ONE;
                        dx_neg_d  = 1'b0;
                        point     = 1'b1;
                    end else begin
                        x_d = w_x_n[10:0];
                    end

`ifdef BALL_CTL_SPEEDUP_EN
                    if (w_hit_l || w_hit_r) begin
                        hits_d = hits_q + 2'd1;
                        if ((hits_q == 2'd3) && (mag_q < MAG_MAX)) begin
                            mag_d = mag_q + MAG_W'(1);
                        end
                    end
`endif

                    if (point) begin
                        x_d     = BALL_X_CENTRE;
                        y_d     = BALL_Y_CENTRE;
                        cnt_d   = SERVE_LOAD;
                        state_d = ((score_l_d == WIN_S) || (score_r_d == WIN_S)) ? GAME_OVER : SERVE;
`ifdef BALL_CTL_SPEEDUP_EN
                        mag_d   = MAG_INIT;
                        hits_d  = 2'd0;
`endif
                    end
                end
            end
            GAME_OVER: begin
                if (start) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    state_d   = SERVE;
                    cnt_d     = SERVE_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        game_over_d = (state_d == GAME_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= BALL_X_CENTRE;
            y_q         <= BALL_Y_CENTRE;
            score_l_q   <= '0;
            score_r_q   <= '0;
            game_over_q <= 1'b0;
            dx_neg_q    <= 1'b0;
            dy_neg_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            game_over_q <= game_over_d;
            dx_neg_q    <= dx_neg_d;
            dy_neg_q    <= dy_neg_d;
        end
    end

    assign x_ball      = x_q;
    assign y_ball      = y_q;
    assign score_left  = score_l_q;
    assign score_right = score_r_q;
    assign game_over   = game_over_q;
endmodule
`default_nettype wire

// File: tb/tb_ball_ctl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ball_ctl : directed scenarios for ball_ctl against a frame     |
// | level game model. Rev 1.0                                         |
// +------------------------------------------------------------------+
module tb_ball_ctl;
    localparam int STEP_X       = 4;
    localparam int STEP_Y       = 3;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN          = 3;

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_PLAY  = 2;
    localparam int M_OVER  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vblnk;
    logic        start;
    logic [9:0]  y_pad_left;
    logic [9:0]  y_pad_right;
    logic [10:0] x_ball;
    logic [9:0]  y_ball;
    logic [3:0]  score_left;
    logic [3:0]  score_right;
    logic        game_over;

    int n_checks = 0;
    int n_fail   = 0;

    // model of the game, advanced once per clock from the same inputs the DUT sees
    int m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_st, m_cnt, m_go;
    bit m_vprev;
    int lmode;

    ball_ctl #(
        .STEP_X       (STEP_X),
        .STEP_Y       (STEP_Y),
        .SERVE_FRAMES (SERVE_FRAMES),
        .WIN_SCORE    (WIN),
        .MAX_STEP_X   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vblnk       (vblnk),
        .start       (start),
        .y_pad_left  (y_pad_left),
        .y_pad_right (y_pad_right),
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .score_left  (score_left),
        .score_right (score_right),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 504; m_y = 376; m_dx = STEP_X; m_dy = STEP_Y;
        m_sl = 0; m_sr = 0; m_st = M_IDLE; m_cnt = 0; m_go = 0; m_vprev = 1'b0;
    endtask

    task automatic model_play();
        int xn, yn, nx, ny, ypl, ypr;
        bit hit_l, hit_r, pt;
        ypl = int'(y_pad_left);
        ypr = int'(y_pad_right);
        xn = m_x + m_dx;
        yn = m_y + m_dy;
        pt = 1'b0;
        if (yn <= 0) begin
            ny = 0; m_dy = STEP_Y;
        end else if (yn >= 752) begin
            ny = 752; m_dy = -STEP_Y;
        end else begin
            ny = yn;
        end
        hit_l = (m_dx < 0) && (m_x > 48) && (xn <= 48) && (m_y + 16 >= ypl) && (m_y <= ypl + 128);
        hit_r = (m_dx > 0) && (m_x < 960) && (xn >= 960) && (m_y + 16 >= ypr) && (m_y <= ypr + 128);
        nx = xn;
        if (hit_l) begin
            nx = 49; m_dx = STEP_X;
        end else if (hit_r) begin
            nx = 959; m_dx = -STEP_X;
        end else if (xn <= 0) begin
            m_sr = (m_sr < WIN) ? m_sr + 1 : WIN; m_dx = -STEP_X; pt = 1'b1;
        end else if (xn >= 1008) begin
            m_sl = (m_sl < WIN) ? m_sl + 1 : WIN; m_dx = STEP_X; pt = 1'b1;
        end
        if (pt) begin
            m_x = 504; m_y = 376; m_cnt = SERVE_FRAMES;
            m_st = (m_sl == WIN || m_sr == WIN) ? M_OVER : M_SERVE;
        end else begin
            m_x = nx; m_y = ny;
        end
    endtask

    task automatic model_cycle();
        bit tk;
        tk = vblnk && !m_vprev;
        m_vprev = vblnk;
        case (m_st)
            M_IDLE:  if (start) begin m_st = M_SERVE; m_cnt = SERVE_FRAMES; end
            M_SERVE: if (tk) begin m_cnt--; if (m_cnt == 0) m_st = M_PLAY; end
            M_PLAY:  if (tk) model_play();
            default: if (start) begin m_sl = 0; m_sr = 0; m_st = M_SERVE; m_cnt = SERVE_FRAMES; end
        endcase
        m_go = (m_st == M_OVER) ? 1 : 0;
    endtask

    // compare on the falling edge, then advance the model to the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            check("cyc_x", int'(x_ball), m_x);
            check("cyc_y", int'(y_ball), m_y);
            check("cyc_score_l", int'(score_left), m_sl);
            check("cyc_score_r", int'(score_right), m_sr);
            check("cyc_game_over", int'(game_over), m_go);
            if (rst_n) model_cycle();
        end
    end

    function automatic logic [9:0] track(input int y);
        return (y >= 50) ? 10'(y - 50) : 10'd0;
    endfunction

    // one frame: pads placed, vblnk high one cycle, low three; ends at posedge+1
    task automatic frame();
        y_pad_right = track(m_y);
        if (lmode == 0) y_pad_left = track(m_y);
        else            y_pad_left = (m_y > 400) ? 10'd0 : 10'd600;
        vblnk = 1'b1;
        @(posedge clk); #1;
        vblnk = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_centre_idle(input string tag);
        check({tag, "_x"}, int'(x_ball), 504);
        check({tag, "_y"}, int'(y_ball), 376);
        check({tag, "_sl"}, int'(score_left), 0);
        check({tag, "_sr"}, int'(score_right), 0);
        check({tag, "_go"}, int'(game_over), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int xb;
        rst_n = 1'b0; vblnk = 1'b0; start = 1'b0;
        y_pad_left = 10'd0; y_pad_right = 10'd0; lmode = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // idle: ball parked, no movement
        repeat (3) frame();
        check_centre_idle("s1");

        // serve countdown then first move
        pulse_start();
        repeat (SERVE_FRAMES) frame();
        check("s2_hold_x", int'(x_ball), 504);
        frame();
        check("s2_x", int'(x_ball), 508);
        check("s2_y", int'(y_ball), 379);

        // top wall clamp
        n = 0;
        while (!(m_y == 2 && m_dy < 0) && n < 3000) begin frame(); n++; end
        check("s3_reach", (n < 3000) ? 1 : 0, 1);
        frame();
        check("s3_y0", int'(y_ball), 0);
        frame();
        check("s3_y3", int'(y_ball), 3);

        // left pad bounce
        n = 0;
        while (!(m_dx < 0 && m_x - 4 <= 48) && n < 3000) begin frame(); n++; end
        check("s4_reach", (n < 3000) ? 1 : 0, 1);
        frame();
        check("s4_bounce_x", int'(x_ball), 49);
        frame();
        check("s4_after_x", int'(x_ball), 53);

        // pad away from ball: no bounce, right scores, serve goes left
        n = 0;
        while (!(m_dx < 0 && m_x - 4 <= 48 && m_y > 400) && n < 6000) begin frame(); n++; end
        check("s5_reach", (n < 6000) ? 1 : 0, 1);
        lmode = 1;
        xb = m_x;
        frame();
        check("s5_nobounce_x", int'(x_ball), xb - 4);
        n = 0;
        while (m_sr == 0 && n < 200) begin frame(); n++; end
        check("s5_score_r", int'(score_right), 1);
        check("s5_x", int'(x_ball), 504);
        check("s5_y", int'(y_ball), 376);
        check("s5_go", int'(game_over), 0);
        repeat (SERVE_FRAMES) frame();
        check("s5_serve_x", int'(x_ball), 504);
        frame();
        check("s5_first_x", int'(x_ball), 500);

        // two more misses end the game
        n = 0;
        while (m_st != M_OVER && n < 3000) begin frame(); n++; end
        check("s6_go", int'(game_over), 1);
        check("s6_sr", int'(score_right), 3);
        check("s6_x", int'(x_ball), 504);
        repeat (3) frame();
        check("s6_frozen_x", int'(x_ball), 504);
        check("s6_frozen_y", int'(y_ball), 376);
        pulse_start();
        check("s6_restart_go", int'(game_over), 0);
        check("s6_restart_sl", int'(score_left), 0);
        check("s6_restart_sr", int'(score_right), 0);

        // reset in the middle of play
        lmode = 0;
        repeat (SERVE_FRAMES + 3) frame();
        check("s7_moving", (int'(x_ball) != 504) ? 1 : 0, 1);
        vblnk = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check_centre_idle("s7_rst");
        @(posedge clk); #1;
        vblnk = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (3) frame();
        check_centre_idle("s7_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
